// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one upstream full-line read/write request into a
// BEATS-long burst on the physical-memory port and pulses resp_o when done.
module cacheline_adaptor #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
);

    localparam int unsigned BEATS      = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned CNT_W      = $clog2(BEATS);
    localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [LINE_WIDTH-1:0] line_buf;

    // Beat counter wraps naturally to 0 after the last beat.
    assign cnt_nxt = cnt + CNT_W'(1);

    // Holds the write line, or collects read beats, for the burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            line_buf  <= '0;
            line_o    <= '0;
            resp_o    <= 1'b0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            address_o <= '0;
            burst_o   <= '0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (write_i) begin
                        state     <= WRITE;
                        line_buf  <= line_i;
                        write_o   <= 1'b1;
                        address_o <= address_i & ALIGN_MASK;
                        burst_o   <= line_i[BURST_WIDTH-1:0];
                    end else if (read_i) begin
                        state     <= READ;
                        read_o    <= 1'b1;
                        address_o <= address_i & ALIGN_MASK;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_buf[32'(cnt) * BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        cnt <= cnt_nxt;
                        if (cnt == LAST_BEAT) begin
                            state     <= DONE;
                            resp_o    <= 1'b1;
                            read_o    <= 1'b0;
                            address_o <= '0;
                            line_o    <= {burst_i, line_buf[LINE_WIDTH-BURST_WIDTH-1:0]};
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt <= cnt_nxt;
                        if (cnt == LAST_BEAT) begin
                            state     <= DONE;
                            resp_o    <= 1'b1;
                            write_o   <= 1'b0;
                            address_o <= '0;
                            burst_o   <= '0;
                        end else begin
                            burst_o <= line_buf[32'(cnt_nxt) * BURST_WIDTH +: BURST_WIDTH];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor: reads, writes, stalls,
// read/write priority, mid-burst reset and back-to-back reads.
module tb_cacheline_adaptor;

    localparam int unsigned LW = 256;
    localparam int unsigned BW = 64;
    localparam int unsigned AW = 32;

    logic          clk;
    logic          rst;
    logic          read_i;
    logic          write_i;
    logic [AW-1:0] address_i;
    logic [LW-1:0] line_i;
    logic [LW-1:0] line_o;
    logic          resp_o;
    logic          read_o;
    logic          write_o;
    logic [AW-1:0] address_o;
    logic [BW-1:0] burst_o;
    logic [BW-1:0] burst_i;
    logic          resp_i;

    int n_total;
    int n_pass;
    int n_fail;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .read_i    (read_i),
        .write_i   (write_i),
        .address_i (address_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .address_o (address_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_resp"}, LW'(resp_o), LW'(1'b0));
        chk({tag, "_read"}, LW'(read_o), LW'(1'b0));
        chk({tag, "_write"}, LW'(write_o), LW'(1'b0));
        chk({tag, "_addr"}, LW'(address_o), LW'(0));
        chk({tag, "_burst"}, LW'(burst_o), LW'(0));
    endtask

    logic [BW-1:0] b0, b1, b2, b3;
    logic [LW-1:0] exp_line;
    logic [3:0]    stall_pat [7];
    logic [BW-1:0] stall_data [4];

    initial begin
        n_total = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0;
        line_i = '0; burst_i = '0; resp_i = 1'b0;
        tick(); tick();
        chk_idle_outputs("reset");
        chk("reset_line", line_o, LW'(0));
        rst = 1'b0;
        tick();

        // Zero-wait read
        read_i = 1'b1; address_i = 32'h0000_1234;
        tick();
        chk("rd_read_o", LW'(read_o), LW'(1'b1));
        chk("rd_addr", LW'(address_o), LW'(32'h0000_1220));
        b0 = 64'h1111_1111_1111_1111; b1 = 64'h2222_2222_2222_2222;
        b2 = 64'h3333_3333_3333_3333; b3 = 64'h4444_4444_4444_4444;
        resp_i = 1'b1;
        burst_i = b0; tick();
        chk("rd_no_early_resp", LW'(resp_o), LW'(1'b0));
        burst_i = b1; tick();
        burst_i = b2; tick();
        burst_i = b3; tick();
        exp_line = {b3, b2, b1, b0};
        chk("rd_resp", LW'(resp_o), LW'(1'b1));
        chk("rd_line", line_o, exp_line);
        chk("rd_read_low", LW'(read_o), LW'(1'b0));
        read_i = 1'b0; resp_i = 1'b0; burst_i = '0;
        tick();
        chk("rd_resp_one_cycle", LW'(resp_o), LW'(1'b0));

        // Write with resp_i held high
        b0 = 64'hAAAA_AAAA_AAAA_AAAA; b1 = 64'hBBBB_BBBB_BBBB_BBBB;
        b2 = 64'hCCCC_CCCC_CCCC_CCCC; b3 = 64'hDDDD_DDDD_DDDD_DDDD;
        write_i = 1'b1; address_i = 32'h8000_00FF; line_i = {b3, b2, b1, b0}; resp_i = 1'b1;
        tick();
        chk("wr_write_o", LW'(write_o), LW'(1'b1));
        chk("wr_read_o", LW'(read_o), LW'(1'b0));
        chk("wr_addr", LW'(address_o), LW'(32'h8000_00E0));
        chk("wr_beat0", LW'(burst_o), LW'(b0)); tick();
        chk("wr_beat1", LW'(burst_o), LW'(b1)); tick();
        chk("wr_beat2", LW'(burst_o), LW'(b2)); tick();
        chk("wr_beat3", LW'(burst_o), LW'(b3));
        chk("wr_beat3_no_resp", LW'(resp_o), LW'(1'b0));
        tick();
        chk("wr_resp", LW'(resp_o), LW'(1'b1));
        chk("wr_write_low", LW'(write_o), LW'(1'b0));
        chk("wr_line_kept", line_o, exp_line);
        write_i = 1'b0; resp_i = 1'b0;
        tick();
        chk("wr_resp_one_cycle", LW'(resp_o), LW'(1'b0));

        // Read with stalled beats: resp_i = 1,0,0,1,1,0,1
        stall_pat = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1};
        stall_data = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                       64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
        read_i = 1'b1; address_i = 32'h0000_4040;
        tick();
        begin
            int k;
            k = 0;
            for (int i = 0; i < 7; i++) begin
                chk($sformatf("st_read_o_c%0d", i), LW'(read_o), LW'(1'b1));
                chk($sformatf("st_no_resp_c%0d", i), LW'(resp_o), LW'(1'b0));
                if (stall_pat[i] == 4'd1) begin
                    resp_i = 1'b1; burst_i = stall_data[k]; k++;
                end else begin
                    resp_i = 1'b0; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
                end
                tick();
            end
        end
        exp_line = {stall_data[3], stall_data[2], stall_data[1], stall_data[0]};
        chk("st_resp", LW'(resp_o), LW'(1'b1));
        chk("st_line", line_o, exp_line);
        read_i = 1'b0; resp_i = 1'b0; burst_i = '0;
        tick();

        // Simultaneous read_i and write_i: write wins, line_o untouched
        read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0100;
        line_i = {4{64'h5A5A_5A5A_5A5A_5A5A}};
        tick();
        chk("both_write_o", LW'(write_o), LW'(1'b1));
        chk("both_read_o", LW'(read_o), LW'(1'b0));
        resp_i = 1'b1;
        tick(); tick(); tick(); tick();
        chk("both_resp", LW'(resp_o), LW'(1'b1));
        chk("both_line_kept", line_o, exp_line);
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        tick();

        // Reset while beat 2 of a write is on the bus
        write_i = 1'b1; address_i = 32'h0000_0200; resp_i = 1'b1;
        line_i = {64'h0D, 64'h0C, 64'h0B, 64'h0A};
        tick(); tick(); tick();
        chk("rstmid_beat2", LW'(burst_o), LW'(64'h0C));
        #1 rst = 1'b1;
        #1;
        chk_idle_outputs("rstmid");
        chk("rstmid_line", line_o, LW'(0));
        write_i = 1'b0; resp_i = 1'b0;
        #1 rst = 1'b0;
        tick();
        chk("rstmid_no_resp", LW'(resp_o), LW'(1'b0));
        chk("rstmid_idle", LW'(write_o), LW'(1'b0));

        read_i = 1'b1; address_i = 32'h0000_2468;
        tick();
        chk("post_rst_addr", LW'(address_o), LW'(32'h0000_2460));
        b0 = 64'h5555_5555_5555_5555; b1 = 64'h6666_6666_6666_6666;
        b2 = 64'h7777_7777_7777_7777; b3 = 64'h8888_8888_8888_8888;
        resp_i = 1'b1;
        burst_i = b0; tick();
        burst_i = b1; tick();
        burst_i = b2; tick();
        burst_i = b3; tick();
        chk("post_rst_resp", LW'(resp_o), LW'(1'b1));
        chk("post_rst_line", line_o, {b3, b2, b1, b0});
        read_i = 1'b0; resp_i = 1'b0;
        tick();

        // Back-to-back reads with read_i held through resp_o
        read_i = 1'b1; address_i = 32'h0000_9999;
        tick();
        chk("b2b_addr", LW'(address_o), LW'(32'h0000_9980));
        resp_i = 1'b1;
        burst_i = 64'hA1; tick();
        burst_i = 64'hA2; tick();
        burst_i = 64'hA3; tick();
        burst_i = 64'hA4; tick();
        chk("b2b_resp1", LW'(resp_o), LW'(1'b1));
        chk("b2b_line1", line_o, {64'hA4, 64'hA3, 64'hA2, 64'hA1});
        resp_i = 1'b0; burst_i = '0;
        tick();
        chk("b2b_gap_read_o", LW'(read_o), LW'(1'b0));
        chk("b2b_gap_resp", LW'(resp_o), LW'(1'b0));
        tick();
        chk("b2b_restart", LW'(read_o), LW'(1'b1));
        read_i = 1'b0; resp_i = 1'b1;
        burst_i = 64'hB1; tick();
        burst_i = 64'hB2; tick();
        burst_i = 64'hB3; tick();
        chk("b2b_no_early_resp2", LW'(resp_o), LW'(1'b0));
        burst_i = 64'hB4; tick();
        chk("b2b_resp2", LW'(resp_o), LW'(1'b1));
        chk("b2b_line2", line_o, {64'hB4, 64'hB3, 64'hB2, 64'hB1});
        resp_i = 1'b0; burst_i = '0;
        tick(); tick();
        chk("b2b_end_read_o", LW'(read_o), LW'(1'b0));
        chk("b2b_end_resp", LW'(resp_o), LW'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
